aes_iter_core: RTL and testbench
================================

Name: aes_iter_core

Overview:
- Iterative, area-reduced AES encryption core: one round per clock, replacing one-block-per-cycle throughput with a single shared round datapath.
- Supports AES-128, AES-192 and AES-256, selectable per block at run time.
- Key expansion runs once per new key into an internal round-key store; later blocks can reuse the stored schedule.
- Sits behind a valid/ready stream interface for use in low-throughput control paths where a fully unrolled core is too large.

Parameters:
SUPPORT_192, 1, 1 = key_len 2'd1 legal; 0 = treated as illegal, AES-192 logic removed
SUPPORT_256, 1, 1 = key_len 2'd2 legal; 0 = treated as illegal, AES-256 logic removed
RK_WORDS, 60, round-key store depth in 32-bit words; must be >= 4*(Nr_max+1), i.e. 44/52/60

Ports:
clk        input   1    clock, all state on rising edge
rst        input   1    asynchronous active-high reset
in_valid   input   1    request valid
in_ready   output  1    core idle and able to accept a request
key_len    input   2    0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = illegal
key_new    input   1    1 = expand key; 0 = reuse stored schedule
key        input   256  key, MSB-aligned; 128/192-bit keys use key[255:128] / key[255:64]
state      input   128  plaintext block
out_valid  output  1    result valid, held until accepted
out_ready  input   1    consumer accepts the result
out        output  128  ciphertext
err        output  1    1-cycle pulse: request rejected

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE; in_ready=1, out_valid=0, err=0, out=0; stored-schedule-valid flag (sv) cleared; round counter cleared.
- Nr = 10 / 12 / 14 and Nk = 4 / 6 / 8 for key_len 0 / 1 / 2.
- Accept a request when in_valid && in_ready. All inputs are sampled only on that cycle.
- Reject the request if any of these holds: key_len==3; key_len not supported by SUPPORT_192/SUPPORT_256; key_new==0 with sv==0; key_new==0 with key_len differing from the stored length.
  - On reject: err=1 on the next cycle, no output produced, FSM stays in IDLE.
- FSM states and transitions:
  - IDLE: on accept, latch the block and XOR it later with round key 0. Go to KEYEXP if key_new, else ROUND.
  - KEYEXP: store w[0..Nk-1] from key on the accept edge. Then generate one word per cycle, w[i] for i = Nk .. 4(Nr+1)-1 (40 / 46 / 52 cycles).
    - Standard FIPS-197 expansion: RotWord+SubWord+Rcon when i mod Nk == 0.
    - AES-256 only: SubWord alone when i mod 8 == 4.
    - Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
    - Leaving KEYEXP: sv=1 and record key_len. Go to ROUND.
  - ROUND: first cycle computes s = block ^ rk0, then applies rounds 1..Nr-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey), one per cycle. Counter r runs 1..Nr-1; then go to FINAL.
  - FINAL: apply the last round (no MixColumns) with rk[Nr]; register the result into out; out_valid=1; go to DONE.
  - DONE: hold out and out_valid until out_ready. On that edge out_valid=0, in_ready=1, return to IDLE.
    - out keeps its last value after acceptance.
    - in_ready is 0 in DONE, so there is no accept/return overlap.
- Latency, accept edge to first out_valid=1 cycle:
  - key_new=0: Nr+1 cycles.
  - key_new=1: expansion cycles + Nr + 1, i.e. 51 / 59 / 67 for 128 / 192 / 256.
- Round key for round r is words w[4r..4r+3], read from the store; the read is combinational or pre-fetched one cycle early with no added latency.
- in_ready=1 only in IDLE. A request with in_valid held high while busy is not accepted until IDLE.
- Reset mid-operation: abort immediately and clear sv. The next key_new=0 request is rejected.
- out_ready asserted while out_valid=0 is ignored.

Optional Feature:
Macro AES_PERF_CNT_EN.
- Defined: adds output blk_cnt [31:0], reset 0. It increments on each out_valid && out_ready handshake, wraps 0xFFFFFFFF -> 0, and is not cleared by rejects.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- AES-128, key_new=1, key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 51 cycles after accept.
- AES-192, key 000102…1516 17, same state -> dda97ca4864cdfe06eaf70a0ec0d7191 at 59 cycles. Then a second block with key_new=0 -> same result at 13 cycles.
- AES-256, key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089 at 67 cycles. Hold out_ready=0 for 20 cycles -> out stable, in_ready=0 throughout.
- Reject cases, each giving err pulse, no out_valid, in_ready back to 1: key_len=3; key_new=0 right after reset; key_len=1 with SUPPORT_192=0; key_new=0 with key_len mismatching the stored length.
- Assert rst during the 30th KEYEXP cycle -> outputs at reset values asynchronously. A following key_new=0 request is rejected; key_new=1 completes correctly.
- With AES_PERF_CNT_EN: 3 accepted blocks plus 1 rejected request -> blk_cnt=3. Force the count to 0xFFFFFFFF then complete one block -> blk_cnt=0.

Source files
------------

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encryptor, one round per clock, with a stored key schedule.
// Optional build macro AES_PERF_CNT_EN adds the blk_cnt completed-block counter output.
`default_nettype none

module aes_iter_core #(
    parameter int SUPPORT_192 = 1,
    parameter int SUPPORT_256 = 1,
    parameter int RK_WORDS    = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   key_len,
    input  logic         key_new,
    input  logic [255:0] key,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         err
`ifdef AES_PERF_CNT_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ROUND, S_FINAL, S_DONE} state_t;

    state_t       fsm_q;
    logic         in_ready_q, out_valid_q, err_q, sv_q;
    logic [127:0] out_q, s_q;
    logic [1:0]   kl_q, skl_q;
    logic [3:0]   r_q;
    logic [5:0]   wi_q;
    logic [2:0]   kmod_q;
    logic [7:0]   rcon_q;
    logic [31:0]  rk_q [RK_WORDS];
`ifdef AES_PERF_CNT_EN
    logic [31:0]  blk_cnt_q;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t, y;
        t = x;
        y = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            y = gmul(y, t);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte k of the block sits at row k%4, column k/4, MSB first.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [3:0]   w_nr, w_nk;
    logic [2:0]   w_nkm1;
    logic [5:0]   w_last, w_in_nk, w_rb;
    logic         w_reject;
    logic [31:0]  w_prev, w_back, w_temp, kw_d;
    logic [127:0] w_rk, w_sr, rs_d;

    always_comb begin
        w_nr = 4'd14; w_nk = 4'd8; w_nkm1 = 3'd7; w_last = 6'd59;
        case (kl_q)
            2'd0: begin w_nr = 4'd10; w_nk = 4'd4; w_nkm1 = 3'd3; w_last = 6'd43; end
            2'd1: begin w_nr = 4'd12; w_nk = 4'd6; w_nkm1 = 3'd5; w_last = 6'd51; end
            default: ;
        endcase
        w_in_nk = (key_len == 2'd0) ? 6'd4 : (key_len == 2'd1) ? 6'd6 : 6'd8;
        w_reject = (key_len == 2'd3)
                || (key_len == 2'd1 && SUPPORT_192 == 0)
                || (key_len == 2'd2 && SUPPORT_256 == 0)
                || (!key_new && (!sv_q || key_len != skl_q));
    end

    always_comb begin
        w_prev = rk_q[wi_q - 6'd1];
        w_back = rk_q[wi_q - {2'b00, w_nk}];
        w_temp = w_prev;
        if (kmod_q == 3'd0)
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
        else if (SUPPORT_256 != 0 && w_nk == 4'd8 && kmod_q == 3'd4)
            w_temp = sub_word(w_prev);
        kw_d = w_back ^ w_temp;
    end

    always_comb begin
        w_rb = {r_q, 2'b00};
        w_rk = {rk_q[w_rb], rk_q[w_rb + 6'd1], rk_q[w_rb + 6'd2], rk_q[w_rb + 6'd3]};
        w_sr = sub_shift(s_q);
        rs_d = (r_q == 4'd0) ? (s_q ^ w_rk) : (mix_cols(w_sr) ^ w_rk);
    end

    // Schedule store is deliberately unreset; sv_q alone says whether it is usable.
    always_ff @(posedge clk) begin
        if (fsm_q == S_IDLE && in_valid && !w_reject && key_new) begin
            for (int i = 0; i < 8; i++) rk_q[i] <= key[255-32*i -: 32];
        end else if (fsm_q == S_KEYEXP) begin
            rk_q[wi_q] <= kw_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            out_q       <= '0;
            s_q         <= '0;
            sv_q        <= 1'b0;
            kl_q        <= 2'd0;
            skl_q       <= 2'd0;
            r_q         <= 4'd0;
            wi_q        <= 6'd0;
            kmod_q      <= 3'd0;
            rcon_q      <= 8'h01;
`ifdef AES_PERF_CNT_EN
            blk_cnt_q   <= 32'd0;
`endif
        end else begin
            err_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_reject) begin
                            err_q <= 1'b1;
                        end else begin
                            in_ready_q <= 1'b0;
                            s_q        <= state;
                            kl_q       <= key_len;
                            r_q        <= 4'd0;
                            wi_q       <= w_in_nk;
                            kmod_q     <= 3'd0;
                            rcon_q     <= 8'h01;
                            fsm_q      <= key_new ? S_KEYEXP : S_ROUND;
                        end
                    end
                end
                S_KEYEXP: begin
                    wi_q   <= wi_q + 6'd1;
                    kmod_q <= (kmod_q == w_nkm1) ? 3'd0 : kmod_q + 3'd1;
                    if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (wi_q == w_last) begin
                        sv_q  <= 1'b1;
                        skl_q <= kl_q;
                        fsm_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    s_q <= rs_d;
                    r_q <= r_q + 4'd1;
                    if (r_q == w_nr - 4'd1) fsm_q <= S_FINAL;
                end
                S_FINAL: begin
                    out_q       <= w_sr ^ w_rk;
                    out_valid_q <= 1'b1;
                    fsm_q       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= S_IDLE;
`ifdef AES_PERF_CNT_EN
                        blk_cnt_q   <= blk_cnt_q + 32'd1;
`endif
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign err       = err_q;
`ifdef AES_PERF_CNT_EN
    assign blk_cnt   = blk_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_iter_core.sv
// Directed self-checking bench for aes_iter_core using the FIPS-197 appendix C vectors.
`default_nettype none

module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, key_new = 1'b0, out_ready = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key = '0;
    logic [127:0] state = '0;
    logic         in_ready, out_valid, err;
    logic [127:0] out;

    logic         in_valid2 = 1'b0, key_new2 = 1'b0, out_ready2 = 1'b0;
    logic [1:0]   key_len2 = 2'd0;
    logic         in_ready2, out_valid2, err2;
    logic [127:0] out2;
`ifdef AES_PERF_CNT_EN
    logic [31:0]  blk_cnt, blk_cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_iter_core u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key_len(key_len), .key_new(key_new), .key(key), .state(state),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .err(err)
`ifdef AES_PERF_CNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    aes_iter_core #(.SUPPORT_192(0)) u_dut_n192 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .key_len(key_len2), .key_new(key_new2), .key(K192), .state(PT),
        .out_valid(out_valid2), .out_ready(out_ready2), .out(out2), .err(err2)
`ifdef AES_PERF_CNT_EN
        , .blk_cnt(blk_cnt2)
`endif
    );

    // Called 1 time unit after a rising edge; returns at the same phase after the accept edge.
    task automatic send(input logic [1:0] kl, input logic kn, input logic [255:0] k, input logic [127:0] s);
        in_valid = 1'b1; key_len = kl; key_new = kn; key = k; state = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (out !== 128'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
    endtask

    task automatic test_aes128();
        int lat;
        send(2'd0, 1'b1, K128, PT);
        wait_out(lat);
        n_checks++; if (lat !== 51) begin n_fail++; $display("FAIL aes128_latency: got %0d want 51", lat); end
        n_checks++; if (out !== C128) begin n_fail++; $display("FAIL aes128_out: got %h want %h", out, C128); end
        accept_out();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL aes128_ovalid_drop: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL aes128_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out !== C128) begin n_fail++; $display("FAIL aes128_out_kept: got %h want %h", out, C128); end
    endtask

    task automatic test_aes192_reuse();
        int lat;
        send(2'd1, 1'b1, K192, PT);
        wait_out(lat);
        n_checks++; if (lat !== 59) begin n_fail++; $display("FAIL aes192_latency: got %0d want 59", lat); end
        n_checks++; if (out !== C192) begin n_fail++; $display("FAIL aes192_out: got %h want %h", out, C192); end
        accept_out();
        send(2'd1, 1'b0, 256'h0, PT);
        wait_out(lat);
        n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL aes192_reuse_latency: got %0d want 13", lat); end
        n_checks++; if (out !== C192) begin n_fail++; $display("FAIL aes192_reuse_out: got %h want %h", out, C192); end
        accept_out();
    endtask

    task automatic test_aes256_hold();
        int lat;
        send(2'd2, 1'b1, K256, PT);
        wait_out(lat);
        n_checks++; if (lat !== 67) begin n_fail++; $display("FAIL aes256_latency: got %0d want 67", lat); end
        n_checks++; if (out !== C256) begin n_fail++; $display("FAIL aes256_out: got %h want %h", out, C256); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out !== C256) begin n_fail++; $display("FAIL hold_out cyc %0d: got %h want %h", i, out, C256); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc %0d: got %b want 1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc %0d: got %b want 0", i, in_ready); end
        end
        accept_out();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL aes256_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reject();
        // key_len 3, then a reuse request whose length differs from the stored AES-256 schedule
        send(2'd3, 1'b1, K128, PT);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_len3_err: got %b want 1", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rej_len3_in_ready: got %b want 1", in_ready); end
        send(2'd0, 1'b0, K128, PT);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_mismatch_err: got %b want 1", err); end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rej_no_output cyc %0d: got %b want 0", i, out_valid); end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rej_err_pulse: got %b want 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rej_in_ready: got %b want 1", in_ready); end
        in_valid2 = 1'b1; key_len2 = 2'd1; key_new2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n_checks++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL rej_no192_err: got %b want 1", err2); end
        n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL rej_no192_in_ready: got %b want 1", in_ready2); end
        @(posedge clk); #1;
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rej_no192_out_valid: got %b want 0", out_valid2); end
        n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL rej_no192_err_pulse: got %b want 0", err2); end
    endtask

    task automatic test_reset_midop();
        int lat;
        send(2'd0, 1'b1, K128, PT);
        repeat (29) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out !== 128'h0) begin n_fail++; $display("FAIL midrst_out: got %h want 0", out); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        send(2'd0, 1'b0, K128, PT);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL midrst_reuse_err: got %b want 1", err); end
        send(2'd0, 1'b1, K128, PT);
        wait_out(lat);
        n_checks++; if (lat !== 51) begin n_fail++; $display("FAIL midrst_latency: got %0d want 51", lat); end
        n_checks++; if (out !== C128) begin n_fail++; $display("FAIL midrst_out_value: got %h want %h", out, C128); end
        accept_out();
    endtask

`ifdef AES_PERF_CNT_EN
    task automatic test_perf();
        int lat;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(2'd0, 1'b1, K128, PT); wait_out(lat); accept_out();
        send(2'd0, 1'b0, K128, PT); wait_out(lat); accept_out();
        send(2'd3, 1'b1, K128, PT);
        @(posedge clk); #1;
        send(2'd0, 1'b0, K128, PT); wait_out(lat); accept_out();
        n_checks++; if (blk_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_count: got %0d want 3", blk_cnt); end
        force u_dut.blk_cnt_q = 32'hFFFF_FFFF;
        #1 release u_dut.blk_cnt_q;
        send(2'd0, 1'b0, K128, PT); wait_out(lat); accept_out();
        n_checks++; if (blk_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_wrap: got %h want 0", blk_cnt); end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_aes128();
        test_aes192_reuse();
        test_aes256_hold();
        test_reject();
        test_reset_midop();
`ifdef AES_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
